uart_tx_dev: RTL and testbench
==============================

Name: uart_tx_dev

Overview:
- Third bridge-side peripheral (DEV2): memory-mapped UART transmitter that responds to CPU stores and loads routed through the bridge.
- Buffers bytes in a small FIFO and serializes them 8N1, LSB first, on a single output line.
- Raises a level interrupt toward the CPU when the queue drains, so software can refill it without polling.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the transmit FIFO; power of two, 2..16.
- DIV_RESET, 16'd434, reset value of the baud divisor register (cycles per bit).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- DEV_Addr  input  32  byte address from the bridge; only bits [3:2] decoded.
- DEV_WD  input  32  write data from the bridge.
- DEV2_WE  input  1  write strobe from the bridge; one write per cycle while high.
- DEV2_RD  output  32  read data, combinational on DEV_Addr[3:2] and current register state.
- intrp2  output  1  interrupt request to CPU, level.
- tx  output  1  serial line, idle high.

Behaviour:
- Register map (word offset = DEV_Addr[3:2]):
  - 0 DATA: write pushes DEV_WD[7:0] into the FIFO; read returns 0.
  - 1 CTRL [2:0]: bit0 EN, bit1 IE, bit2 PODD (see Optional Feature); other bits read 0.
  - 2 STATUS, read-only except clear: bit0 BUSY (shifter active), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[8:4] COUNT. Any write clears OVF.
  - 3 DIV [15:0]: bit period in clk cycles; a value of 0 is treated as 1.
- Reset values:
  - tx=1, intrp2=0, CTRL=0, DIV=DIV_RESET.
  - FIFO empty (COUNT=0), OVF=0, FSM in IDLE.
  - DEV2_RD at reset is therefore 0x4 on STATUS and 0 on the other offsets.
- FIFO:
  - Push on DATA write when not FULL.
  - A push while FULL is dropped and sets OVF; contents are unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle both take effect; COUNT is unchanged.
  - A push when EMPTY is visible to the FSM the following cycle.
- FSM states: IDLE, START, DATA, STOP. The bit counter counts 0..DIV-1 in each state.
  - IDLE: tx=1. If EN and not EMPTY, pop the head into the shift register and enter START on the next edge.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: drive shift[0] for DIV cycles per bit, shift right, 8 bits, then STOP.
  - STOP: tx=1 for DIV cycles, then IDLE.
  - IDLE takes exactly 1 cycle before the next START when the FIFO is non-empty, so a back-to-back frame is 10*DIV+1 cycles.
- BUSY = state != IDLE.
- Clearing EN mid-frame: the current frame completes, then the FSM holds in IDLE. Queued bytes are retained.
- Writing DIV mid-frame: the new value takes effect at the next bit boundary.
- intrp2 = IE & EMPTY & ~BUSY, registered (one cycle after the condition). It deasserts one cycle after the condition drops.
- Asserting reset mid-frame: tx returns to 1 immediately and the frame is abandoned.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - It drives even parity of the 8 data bits when CTRL.PODD=0, odd parity when PODD=1.
  - Frame length becomes 11*DIV cycles.
- When undefined:
  - CTRL bit2 is not stored and reads 0.
  - Frames are 10*DIV cycles.

Test Plan:
- Reset check: reset high -> tx=1, intrp2=0, STATUS read=0x4, DIV read=434, CTRL read=0.
- Single frame: DIV=4, write DATA=0x55, CTRL=1 -> tx low cycles 1-4, then bit pattern 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. BUSY=1 for 40 cycles.
- Overflow: FIFO_DEPTH=4, CTRL=0, write 5 bytes -> STATUS COUNT=4, FULL=1, OVF=1. Write STATUS -> OVF=0 and COUNT still 4.
- Back-to-back: DIV=2, queue 0xA5 and 0x3C, set EN -> two frames separated by exactly 1 idle-high cycle. Total 41 cycles from first start bit to end of second stop.
- Interrupt: CTRL=3, one byte 0xFF, DIV=1 -> intrp2=0 during frame, rises 1 cycle after STOP ends. Writing a new byte drops intrp2 within 2 cycles.
- Parity (macro on): DIV=2, CTRL=5 (EN, PODD), byte 0x07 -> parity bit=0, frame 22 cycles. With CTRL=1 -> parity bit=1.

Source files
------------

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter (bridge device DEV2) with byte FIFO and drain interrupt.
// Optional parity stage is built when UART_TX_PARITY_EN is defined.
module uart_tx_dev #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DEV_Addr,
   input  logic [31:0] DEV_WD,
   input  logic        DEV2_WE,
   output logic [31:0] DEV2_RD,
   output logic        intrp2,
   output logic        tx
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_ovf;
   logic [2:0]        r_ctrl;
   logic [15:0]       r_div;
   logic [15:0]       r_div_lat;
   logic [15:0]       r_cnt;
   logic [2:0]        r_bitidx;
   logic [7:0]        r_shift;
   logic              r_par;
   logic              r_intrp;

   logic [1:0]        w_sel;
   logic              w_wr_data;
   logic              w_wr_ctrl;
   logic              w_wr_stat;
   logic              w_wr_div;
   logic              w_full;
   logic              w_empty;
   logic              w_busy;
   logic              w_push;
   logic              w_pop;
   logic [15:0]       w_div_eff;
   logic              w_bit_end;
   logic [4:0]        w_count5;
   logic              w_tx;
   logic              w_unused;

   assign w_sel     = DEV_Addr[3:2];
   assign w_wr_data = DEV2_WE && (w_sel == 2'd0);
   assign w_wr_ctrl = DEV2_WE && (w_sel == 2'd1);
   assign w_wr_stat = DEV2_WE && (w_sel == 2'd2);
   assign w_wr_div  = DEV2_WE && (w_sel == 2'd3);

   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_busy    = (r_state != S_IDLE);
   assign w_push    = w_wr_data && !w_full;
   assign w_pop     = (r_state == S_IDLE) && r_ctrl[0] && !w_empty;
   assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
   assign w_bit_end = (r_cnt == r_div_lat - 16'd1);
   assign w_count5  = 5'(r_count);
   assign w_unused  = ^{DEV_Addr[31:4], DEV_Addr[1:0], DEV_WD[31:16]};

   // Register file and FIFO bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl  <= '0;
         r_div   <= DIV_RESET;
         r_ovf   <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_ctrl) begin
`ifdef UART_TX_PARITY_EN
            r_ctrl <= DEV_WD[2:0];
`else
            r_ctrl <= {1'b0, DEV_WD[1:0]};
`endif
         end
         if (w_wr_div)
            r_div <= DEV_WD[15:0];
         if (w_wr_data && w_full)
            r_ovf <= 1'b1;
         else if (w_wr_stat)
            r_ovf <= 1'b0;
         if (w_push)
            r_wptr <= AW'(r_wptr + 1'b1);
         if (w_pop)
            r_rptr <= AW'(r_rptr + 1'b1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= DEV_WD[7:0];
   end

   // Divisor is latched per bit so a DIV write only lands on the next bit boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_cnt     <= '0;
         r_div_lat <= 16'd1;
         r_bitidx  <= '0;
      end else if (w_pop) begin
         r_shift   <= r_mem[r_rptr];
         r_par     <= ^r_mem[r_rptr];
         r_cnt     <= '0;
         r_div_lat <= w_div_eff;
         r_bitidx  <= '0;
      end else if (w_busy) begin
         if (w_bit_end) begin
            r_cnt     <= '0;
            r_div_lat <= w_div_eff;
            if (r_state == S_DATA) begin
               r_shift  <= {1'b0, r_shift[7:1]};
               r_bitidx <= r_bitidx + 3'd1;
            end
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_pop) w_next = S_START;
         S_START:  if (w_bit_end) w_next = S_DATA;
         S_DATA: begin
            if (w_bit_end && (r_bitidx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               w_next = S_PARITY;
`else
               w_next = S_STOP;
`endif
            end
         end
         S_PARITY: if (w_bit_end) w_next = S_STOP;
         S_STOP:   if (w_bit_end) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_tx = 1'b1;
      case (r_state)
         S_START:  w_tx = 1'b0;
         S_DATA:   w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_tx = r_par ^ r_ctrl[2];
`endif
         default:  w_tx = 1'b1;
      endcase
   end

   assign tx = w_tx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_intrp <= 1'b0;
      else
         r_intrp <= r_ctrl[1] & w_empty & ~w_busy;
   end

   assign intrp2 = r_intrp;

   always_comb begin
      DEV2_RD = '0;
      case (w_sel)
         2'd1:    DEV2_RD = {29'd0, r_ctrl};
         2'd2:    DEV2_RD = {23'd0, w_count5, r_ovf, w_empty, w_full, w_busy};
         2'd3:    DEV2_RD = {16'd0, r_div};
         default: DEV2_RD = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomized self-checking bench for uart_tx_dev; frames are predicted from the 8N1 bit rules.
module tb_uart_tx_dev;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] DEV_Addr;
   logic [31:0] DEV_WD;
   logic        DEV2_WE;
   logic [31:0] DEV2_RD;
   logic        intrp2;
   logic        tx;

   int checks   = 0;
   int failures = 0;

`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   always #5 clk = ~clk;

   uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
      .clk      (clk),
      .reset    (reset),
      .DEV_Addr (DEV_Addr),
      .DEV_WD   (DEV_WD),
      .DEV2_WE  (DEV2_WE),
      .DEV2_RD  (DEV2_RD),
      .intrp2   (intrp2),
      .tx       (tx)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset    = 1'b1;
      DEV2_WE  = 1'b0;
      DEV_Addr = '0;
      DEV_WD   = '0;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      DEV_Addr = a;
      DEV_WD   = d;
      DEV2_WE  = 1'b1;
      step();
      DEV2_WE  = 1'b0;
   endtask

   // Line level in a given bit slot of a frame: start, 8 data LSB first, [parity], stop
   function automatic logic exp_bit(input logic [7:0] b, input int slot, input logic podd);
      if (slot == 0)
         return 1'b0;
      if (slot <= 8)
         return b[slot-1];
      if (FB == 11 && slot == 9)
         return (^b) ^ podd;
      return 1'b1;
   endfunction

   // Walks the frame cycle by cycle from cycle index 'from'; ends on the first cycle after it
   task automatic run_frame(input logic [7:0] b, input int div, input logic podd,
                            input int from, input string name);
      logic e;
      DEV_Addr = 32'h8;
      for (int i = from; i < FB * div; i++) begin
         #0;
         e = exp_bit(b, i / div, podd);
         checks++;
         if (tx !== e) begin
            failures++;
            $display("FAIL %s tx cycle %0d: got %b expected %b", name, i, tx, e);
         end
         checks++;
         if (DEV2_RD[0] !== 1'b1 || intrp2 !== 1'b0) begin
            failures++;
            $display("FAIL %s busy/intrp cycle %0d: got %b/%b expected 1/0", name, i, DEV2_RD[0], intrp2);
         end
         step();
      end
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      DEV2_WE  = 1'b0;
      DEV_WD   = '0;
      DEV_Addr = 32'h0;
      #2;
      checks++;
      if (tx !== 1'b1 || intrp2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_lines: got tx=%b intrp2=%b expected tx=1 intrp2=0", tx, intrp2);
      end
      for (int k = 0; k < 4; k++) begin
         logic [31:0] e;
         DEV_Addr = 32'(k * 4);
         #1;
         e = (k == 2) ? 32'h4 : (k == 3) ? 32'd434 : 32'h0;
         checks++;
         if (DEV2_RD !== e) begin
            failures++;
            $display("FAIL reset_read off%0d: got %h expected %h", k, DEV2_RD, e);
         end
      end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_frame;
      for (int n = 0; n < 5; n++) begin
         logic [7:0]  b;
         logic [15:0] div;
         logic        podd;
         int          eff;
         b    = (n == 0) ? 8'h55 : 8'($urandom);
         div  = (n == 0) ? 16'd4 : (n == 1) ? 16'd0 : 16'($urandom_range(1, 5));
         podd = 1'b0;
`ifdef UART_TX_PARITY_EN
         podd = 1'($urandom);
`endif
         eff  = (div == 0) ? 1 : int'(div);
         do_reset();
         bus_write(32'hC, {16'd0, div});
         bus_write(32'h0, {24'd0, b});
         bus_write(32'h4, {29'd0, podd, 2'b01});
         step();
         run_frame(b, eff, podd, 0, "single_frame");
         checks++;
         if (tx !== 1'b1 || DEV2_RD !== 32'h4) begin
            failures++;
            $display("FAIL single_frame_end: got tx=%b status=%h expected tx=1 status=4", tx, DEV2_RD);
         end
      end
   endtask

   task automatic test_overflow;
      logic [7:0] q[$];
      do_reset();
      for (int k = 0; k < 5; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (q.size() < 4)
            q.push_back(b);
         bus_write(32'h0, {24'd0, b});
      end
      DEV_Addr = 32'h8;
      #1;
      checks++;
      if (DEV2_RD !== 32'h4A) begin
         failures++;
         $display("FAIL overflow_status: got %h expected 0000004a", DEV2_RD);
      end
      bus_write(32'h8, 32'h0);
      DEV_Addr = 32'h8;
      #1;
      checks++;
      if (DEV2_RD !== 32'h42) begin
         failures++;
         $display("FAIL overflow_clear: got %h expected 00000042", DEV2_RD);
      end
      bus_write(32'hC, 32'd1);
      bus_write(32'h4, 32'd1);
      step();
      while (q.size() > 0) begin
         logic [7:0] b;
         b = q.pop_front();
         run_frame(b, 1, 1'b0, 0, "overflow_contents");
         if (q.size() > 0)
            step();
      end
      checks++;
      if (tx !== 1'b1 || DEV2_RD !== 32'h4) begin
         failures++;
         $display("FAIL overflow_drain: got tx=%b status=%h expected tx=1 status=4", tx, DEV2_RD);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      bus_write(32'hC, 32'd2);
      bus_write(32'h0, 32'hA5);
      bus_write(32'h0, 32'h3C);
      bus_write(32'h4, 32'd1);
      step();
      run_frame(8'hA5, 2, 1'b0, 0, "b2b_first");
      checks++;
      if (tx !== 1'b1 || DEV2_RD[0] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_gap: got tx=%b busy=%b expected tx=1 busy=0", tx, DEV2_RD[0]);
      end
      step();
      run_frame(8'h3C, 2, 1'b0, 0, "b2b_second");
      checks++;
      if (tx !== 1'b1 || DEV2_RD !== 32'h4) begin
         failures++;
         $display("FAIL b2b_end: got tx=%b status=%h expected tx=1 status=4", tx, DEV2_RD);
      end
   endtask

   task automatic test_en_clear;
      logic [7:0] b1;
      logic [7:0] b2;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      do_reset();
      bus_write(32'hC, 32'd3);
      bus_write(32'h0, {24'd0, b1});
      bus_write(32'h0, {24'd0, b2});
      bus_write(32'h4, 32'd1);
      step();
      bus_write(32'h4, 32'd0);
      run_frame(b1, 3, 1'b0, 1, "en_clear_frame");
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (tx !== 1'b1 || DEV2_RD !== 32'h10) begin
            failures++;
            $display("FAIL en_clear_hold: got tx=%b status=%h expected tx=1 status=10", tx, DEV2_RD);
         end
         step();
      end
      bus_write(32'h4, 32'd1);
      step();
      run_frame(b2, 3, 1'b0, 0, "en_clear_resume");
   endtask

   task automatic test_interrupt;
      do_reset();
      bus_write(32'hC, 32'd1);
      bus_write(32'h0, 32'hFF);
      bus_write(32'h4, 32'd3);
      checks++;
      if (intrp2 !== 1'b0) begin
         failures++;
         $display("FAIL intr_before: got %b expected 0", intrp2);
      end
      step();
      run_frame(8'hFF, 1, 1'b0, 0, "intr_frame");
      checks++;
      if (intrp2 !== 1'b0) begin
         failures++;
         $display("FAIL intr_stop_end: got %b expected 0", intrp2);
      end
      step();
      checks++;
      if (intrp2 !== 1'b1) begin
         failures++;
         $display("FAIL intr_rise: got %b expected 1", intrp2);
      end
      bus_write(32'h0, {24'd0, 8'($urandom)});
      step();
      checks++;
      if (intrp2 !== 1'b0) begin
         failures++;
         $display("FAIL intr_drop: got %b expected 0", intrp2);
      end
   endtask

   task automatic test_reset_midframe;
      do_reset();
      bus_write(32'hC, 32'd4);
      bus_write(32'h0, 32'h00);
      bus_write(32'h4, 32'd1);
      for (int k = 0; k < 6; k++)
         step();
      checks++;
      if (tx !== 1'b0) begin
         failures++;
         $display("FAIL midreset_pre: got tx=%b expected 0", tx);
      end
      #2;
      reset    = 1'b1;
      DEV_Addr = 32'h8;
      #1;
      checks++;
      if (tx !== 1'b1 || DEV2_RD !== 32'h4) begin
         failures++;
         $display("FAIL midreset: got tx=%b status=%h expected tx=1 status=4", tx, DEV2_RD);
      end
      step();
      reset = 1'b0;
      step();
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      for (int n = 0; n < 2; n++) begin
         do_reset();
         bus_write(32'hC, 32'd2);
         bus_write(32'h0, 32'h07);
         bus_write(32'h4, (n == 0) ? 32'd5 : 32'd1);
         step();
         run_frame(8'h07, 2, (n == 0), 0, "parity_frame");
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_back_to_back();
      test_en_clear();
      test_interrupt();
      test_reset_midframe();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
